// File: rtl/bus_transfer_ctrl_if.sv
// Command, register-file and bus signals shared between a requester and bus_transfer_ctrl.
// The master side issues commands and supplies register values; the slave side is the controller.
interface bus_transfer_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             Req;
  logic [1:0]       Op;
  logic [1:0]       Src;
  logic [1:0]       Dst;
  logic [WIDTH-1:0] Ext_Data;
  logic [WIDTH-1:0] RegA;
  logic [WIDTH-1:0] RegB;
  logic [WIDTH-1:0] RegC;
  logic [WIDTH-1:0] RegD;
  logic [WIDTH-1:0] Data_Bus;
  logic             A_EN;
  logic             B_EN;
  logic             C_EN;
  logic             D_EN;
  logic [WIDTH-1:0] Ext_Out;
  logic             Ext_Valid;
  logic             Busy;
  logic             Done;
  logic             Err;

  modport master (
    output Req, Op, Src, Dst, Ext_Data, RegA, RegB, RegC, RegD,
    input  Data_Bus, A_EN, B_EN, C_EN, D_EN, Ext_Out, Ext_Valid, Busy, Done, Err
  );

  modport slave (
    input  Req, Op, Src, Dst, Ext_Data, RegA, RegB, RegC, RegD,
    output Data_Bus, A_EN, B_EN, C_EN, D_EN, Ext_Out, Ext_Valid, Busy, Done, Err
  );
endinterface

// File: rtl/bus_transfer_ctrl.sv
// Source/driver controller for the shared four-register data bus: MOV, LOAD and STORE transfers.
// Defining BUS_XCHG_EN adds the register exchange (Op=11); otherwise Op=11 raises Err.
module bus_transfer_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                Clock,
  input logic                Reset,
  bus_transfer_ctrl_if.slave bus
);

  localparam logic [1:0] OP_MOV   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_XCHG  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_XSRC  = 3'd4,
    ST_XDRV  = 3'd5,
    ST_XDST  = 3'd6,
    ST_XFIN  = 3'd7
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [1:0]       op_r, op_nxt_s;
  logic [1:0]       dst_r, dst_nxt_s;
  logic [WIDTH-1:0] data_bus_r, data_bus_nxt_s;
  logic [WIDTH-1:0] ext_out_r, ext_out_nxt_s;
  logic [3:0]       en_r, en_nxt_s;
  logic             ext_valid_r, ext_valid_nxt_s;
  logic             busy_r;
  logic             done_r, done_nxt_s;
  logic             err_r, err_nxt_s;
  logic             err_pend_r, err_pend_nxt_s;
`ifdef BUS_XCHG_EN
  logic [1:0]       src_r, src_nxt_s;
  logic [WIDTH-1:0] temp_r, temp_nxt_s;
`endif

  function automatic logic [WIDTH-1:0] reg_sel(input logic [1:0] idx,
                                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    case (idx)
      2'd0:    reg_sel = a;
      2'd1:    reg_sel = b;
      2'd2:    reg_sel = c;
      2'd3:    reg_sel = d;
      default: reg_sel = a;
    endcase
  endfunction

  function automatic logic [3:0] en_onehot(input logic [1:0] idx);
    en_onehot = 4'b0001 << idx;
  endfunction

  // Next-state and next-output logic; enables and pulses default low so each lasts one cycle
  always_comb begin
    state_nxt_s     = state_r;
    op_nxt_s        = op_r;
    dst_nxt_s       = dst_r;
    data_bus_nxt_s  = data_bus_r;
    ext_out_nxt_s   = ext_out_r;
    en_nxt_s        = 4'b0000;
    ext_valid_nxt_s = 1'b0;
    done_nxt_s      = 1'b0;
    err_nxt_s       = err_pend_r;
    err_pend_nxt_s  = 1'b0;
`ifdef BUS_XCHG_EN
    src_nxt_s       = src_r;
    temp_nxt_s      = temp_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.Req && (bus.Op == OP_XCHG)) begin
`ifdef BUS_XCHG_EN
          op_nxt_s       = bus.Op;
          src_nxt_s      = bus.Src;
          dst_nxt_s      = bus.Dst;
          temp_nxt_s     = reg_sel(bus.Src, bus.RegA, bus.RegB, bus.RegC, bus.RegD);
          data_bus_nxt_s = reg_sel(bus.Dst, bus.RegA, bus.RegB, bus.RegC, bus.RegD);
          state_nxt_s    = ST_XSRC;
`else
          // Err is delayed one cycle so it lands where the first enable would have
          err_pend_nxt_s = 1'b1;
          state_nxt_s    = ST_IDLE;
`endif
        end else if (bus.Req) begin
          op_nxt_s  = bus.Op;
          dst_nxt_s = bus.Dst;
          if (bus.Op == OP_LOAD) begin
            data_bus_nxt_s = bus.Ext_Data;
          end else begin
            data_bus_nxt_s = reg_sel(bus.Src, bus.RegA, bus.RegB, bus.RegC, bus.RegD);
          end
          state_nxt_s = ST_DRIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if ((op_r == OP_MOV) || (op_r == OP_LOAD)) begin
          en_nxt_s = en_onehot(dst_r);
        end else begin
          en_nxt_s = 4'b0000;
        end
        state_nxt_s = ST_WRITE;
      end
      ST_WRITE: begin
        if (op_r == OP_STORE) begin
          ext_out_nxt_s   = data_bus_r;
          ext_valid_nxt_s = 1'b1;
        end else begin
          ext_valid_nxt_s = 1'b0;
        end
        done_nxt_s  = 1'b1;
        state_nxt_s = ST_DONE;
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
`ifdef BUS_XCHG_EN
      ST_XSRC: begin
        en_nxt_s    = en_onehot(src_r);
        state_nxt_s = ST_XDRV;
      end
      ST_XDRV: begin
        data_bus_nxt_s = temp_r;
        state_nxt_s    = ST_XDST;
      end
      ST_XDST: begin
        en_nxt_s    = en_onehot(dst_r);
        state_nxt_s = ST_XFIN;
      end
      ST_XFIN: begin
        done_nxt_s  = 1'b1;
        state_nxt_s = ST_DONE;
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latched command, datapath and registered outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      op_r        <= 2'b00;
      dst_r       <= 2'b00;
      data_bus_r  <= {WIDTH{1'b0}};
      ext_out_r   <= {WIDTH{1'b0}};
      en_r        <= 4'b0000;
      ext_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_pend_r  <= 1'b0;
`ifdef BUS_XCHG_EN
      src_r       <= 2'b00;
      temp_r      <= {WIDTH{1'b0}};
`endif
    end else begin
      op_r        <= op_nxt_s;
      dst_r       <= dst_nxt_s;
      data_bus_r  <= data_bus_nxt_s;
      ext_out_r   <= ext_out_nxt_s;
      en_r        <= en_nxt_s;
      ext_valid_r <= ext_valid_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= done_nxt_s;
      err_r       <= err_nxt_s;
      err_pend_r  <= err_pend_nxt_s;
`ifdef BUS_XCHG_EN
      src_r       <= src_nxt_s;
      temp_r      <= temp_nxt_s;
`endif
    end
  end

  assign bus.Data_Bus  = data_bus_r;
  assign bus.A_EN      = en_r[0];
  assign bus.B_EN      = en_r[1];
  assign bus.C_EN      = en_r[2];
  assign bus.D_EN      = en_r[3];
  assign bus.Ext_Out   = ext_out_r;
  assign bus.Ext_Valid = ext_valid_r;
  assign bus.Busy      = busy_r;
  assign bus.Done      = done_r;
  assign bus.Err       = err_r;

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Randomized scoreboard bench for bus_transfer_ctrl with a behavioural register-file model.
// Honours BUS_XCHG_EN the same way the design does.
`timescale 1ns/1ps
module tb_bus_transfer_ctrl;
  localparam int W = 16;
  localparam logic [1:0] OP_MOV   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_XCHG  = 2'b11;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  bus_transfer_ctrl_if #(.WIDTH(W)) bus ();
  bus_transfer_ctrl #(.WIDTH(W)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  // Register file A-D on the bus side; not reset, so a reset leaves contents untouched
  logic [W-1:0] regs [4] = '{default: '0};
  assign bus.RegA = regs[0];
  assign bus.RegB = regs[1];
  assign bus.RegC = regs[2];
  assign bus.RegD = regs[3];
  always @(posedge Clock) begin
    if (bus.A_EN) regs[0] <= bus.Data_Bus;
    if (bus.B_EN) regs[1] <= bus.Data_Bus;
    if (bus.C_EN) regs[2] <= bus.Data_Bus;
    if (bus.D_EN) regs[3] <= bus.Data_Bus;
  end

  typedef struct packed {
    logic              is_err;
    logic              is_store;
    logic [31:0]       k;
    logic [31:0]       lat;
    logic [W-1:0]      bus_k;
    logic [W-1:0]      bus_fin;
    logic [W-1:0]      ext;
    logic [3:0]        en_mask;
    logic [3:0][W-1:0] regs;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_regs [4];
  logic [W-1:0] m_bus;
  logic [W-1:0] m_ext;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  logic [3:0]   en_seen = 4'b0000;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard on every Done/Err pulse and checks the whole observable state
  always @(negedge Clock) begin : monitor
    exp_t       e;
    logic [3:0] en_now;
    en_now = {bus.D_EN, bus.C_EN, bus.B_EN, bus.A_EN};
    if (en_now != 4'b0000) begin
      check("en_onehot", $countones(en_now), 1);
      en_seen = en_seen | en_now;
    end
    if (exp_q.size() != 0 && exp_q[0].k == cyc) begin
      e = exp_q[0];
      check("bus_at_k", 32'(bus.Data_Bus), 32'(e.bus_k));
      check("busy_at_k", 32'(bus.Busy), 32'(!e.is_err));
    end
    if (bus.Done || bus.Err) begin
      if (exp_q.size() == 0) begin
        check("stray_completion", 32'({bus.Done, bus.Err}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("completion_err", 32'(bus.Err), 32'(e.is_err));
        check("completion_done", 32'(bus.Done), 32'(!e.is_err));
        check("latency", cyc - e.k, e.lat);
        check("en_pulses", 32'(en_seen), 32'(e.en_mask));
        check("ext_valid", 32'(bus.Ext_Valid), 32'(e.is_store));
        check("ext_out", 32'(bus.Ext_Out), 32'(e.ext));
        check("bus_final", 32'(bus.Data_Bus), 32'(e.bus_fin));
        for (int i = 0; i < 4; i++) check("reg_file", 32'(regs[i]), 32'(e.regs[i]));
        en_seen = 4'b0000;
      end
    end else if (bus.Ext_Valid) begin
      check("stray_ext_valid", 32'(bus.Ext_Valid), 32'd0);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge Clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                       input logic [W-1:0] data, input bit poke);
    exp_t         e;
    logic [W-1:0] tmp;
    wait_idle();
    @(negedge Clock);
    bus.Req = 1'b1; bus.Op = op; bus.Src = src; bus.Dst = dst; bus.Ext_Data = data;
    @(posedge Clock); #1;
    // Scramble command inputs after acceptance; they must have no effect
    bus.Req = 1'b0; bus.Op = 2'($urandom); bus.Src = 2'($urandom);
    bus.Dst = 2'($urandom); bus.Ext_Data = W'($urandom);
    e = '0;
    e.k = cyc;
    e.bus_k = m_bus;
    case (op)
      OP_MOV: begin
        e.bus_k = m_regs[src]; m_regs[dst] = m_regs[src];
        e.lat = 2; e.en_mask = 4'b0001 << dst; m_bus = e.bus_k;
      end
      OP_LOAD: begin
        e.bus_k = data; m_regs[dst] = data;
        e.lat = 2; e.en_mask = 4'b0001 << dst; m_bus = data;
      end
      OP_STORE: begin
        e.bus_k = m_regs[src]; m_ext = m_regs[src]; e.is_store = 1'b1;
        e.lat = 2; e.en_mask = 4'b0000; m_bus = e.bus_k;
      end
      default: begin
`ifdef BUS_XCHG_EN
        tmp = m_regs[src];
        e.bus_k = m_regs[dst];
        m_regs[src] = m_regs[dst];
        m_regs[dst] = tmp;
        m_bus = tmp;
        e.lat = 4; e.en_mask = (4'b0001 << src) | (4'b0001 << dst);
`else
        tmp = '0;
        e.is_err = 1'b1; e.lat = 1; e.en_mask = 4'b0000;
`endif
      end
    endcase
    e.bus_fin = m_bus;
    e.ext = m_ext;
    for (int i = 0; i < 4; i++) e.regs[i] = m_regs[i];
    exp_q.push_back(e);
    if (poke) begin
      @(posedge Clock); #1;
      bus.Req = 1'b1; bus.Op = OP_LOAD; bus.Dst = 2'($urandom); bus.Ext_Data = W'($urandom);
      @(posedge Clock); #1;
      bus.Req = 1'b0;
    end
  endtask

  task automatic reset_mid_mov();
    wait_idle();
    @(negedge Clock);
    bus.Req = 1'b1; bus.Op = OP_MOV; bus.Src = 2'd0; bus.Dst = 2'd1;
    @(posedge Clock); #1;
    bus.Req = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;
    #1;
    check("reset_clears_en", 32'(bus.B_EN), 32'd0);
    check("reset_clears_busy", 32'(bus.Busy), 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    m_bus = '0;
    m_ext = '0;
    repeat (6) @(posedge Clock);
    #1;
    check("reset_no_en", 32'(en_seen), 32'd0);
    check("reset_regB", 32'(regs[1]), 32'(m_regs[1]));
    check("reset_bus", 32'(bus.Data_Bus), 32'd0);
    check("reset_ext_out", 32'(bus.Ext_Out), 32'd0);
    check("reset_busy_after", 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000ns");
    $fatal(1);
  end

  initial begin
    logic [1:0]   op, src, dst;
    logic [W-1:0] data;
    bit           poke;
    bus.Req = 1'b1; bus.Op = OP_LOAD; bus.Src = 2'd0; bus.Dst = 2'd0; bus.Ext_Data = 16'h1234;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_bus = '0;
    m_ext = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_bus", 32'(bus.Data_Bus), 32'd0);
    check("rst_en", 32'({bus.D_EN, bus.C_EN, bus.B_EN, bus.A_EN}), 32'd0);
    check("rst_ext_out", 32'(bus.Ext_Out), 32'd0);
    check("rst_ext_valid", 32'(bus.Ext_Valid), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_err", 32'(bus.Err), 32'd0);
    bus.Req = 1'b0;
    Reset = 1'b1;
    repeat (4) @(posedge Clock);
    #1;
    check("idle_busy", 32'(bus.Busy), 32'd0);
    check("idle_bus", 32'(bus.Data_Bus), 32'd0);
    check("idle_en", 32'(en_seen), 32'd0);

    issue(OP_LOAD, 2'd0, 2'd0, 16'h00AA, 1'b0);
    issue(OP_MOV, 2'd0, 2'd2, 16'h0000, 1'b0);
    issue(OP_STORE, 2'd2, 2'd0, 16'h0000, 1'b1);
    reset_mid_mov();
    issue(OP_LOAD, 2'd0, 2'd0, 16'h0001, 1'b0);
    issue(OP_LOAD, 2'd0, 2'd1, 16'h0002, 1'b0);
    issue(OP_XCHG, 2'd0, 2'd1, 16'h0000, 1'b0);
    issue(OP_MOV, 2'd3, 2'd3, 16'h0000, 1'b0);
    issue(OP_LOAD, 2'd3, 2'd3, 16'hFFFF, 1'b0);
    issue(OP_XCHG, 2'd3, 2'd3, 16'h0000, 1'b0);

    for (int i = 0; i < 60; i++) begin
      op   = 2'($urandom);
      src  = 2'($urandom);
      dst  = 2'($urandom);
      data = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
      poke = ($urandom_range(0, 3) == 0);
`ifndef BUS_XCHG_EN
      if (op == OP_XCHG) poke = 1'b0;
`endif
      issue(op, src, dst, data, poke);
    end
    wait_idle();
    repeat (3) @(posedge Clock);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
